// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the bridge CPU-side data port.
// A hold limit bounds how long one master can keep the bus under contention.
module data_bus_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_byteen,
  input  logic [31:0] s_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_nx;
  logic             last_owner;
  logic             last_owner_nx;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nx;
  logic             acc0;
  logic             acc1;

  assign m0_gnt = (state == G0);
  assign m1_gnt = (state == G1);
  assign owner  = state;

  assign acc0 = m0_gnt & m0_req;
  assign acc1 = m1_gnt & m1_req;

  // Idle bus drives zeros so the bridge never sees a stray write.
  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_byteen = '0;
    unique case (1'b1)
      acc0: begin
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_byteen = m0_byteen;
      end
      acc1: begin
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_byteen = m1_byteen;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx      = state;
    hold_cnt_nx   = hold_cnt;
    last_owner_nx = last_owner;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nx = last_owner ? G0 : G1;
        end else if (m0_req) begin
          state_nx = G0;
        end else if (m1_req) begin
          state_nx = G1;
        end
      end
      G0: begin
        if (!m0_req) begin
          state_nx = m1_req ? G1 : IDLE;
        end else if (m1_req) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx = G1;
          end else begin
            hold_cnt_nx = hold_cnt + CNT_W'(1);
          end
        end
      end
      G1: begin
        if (!m1_req) begin
          state_nx = m0_req ? G0 : IDLE;
        end else if (m0_req) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nx = G0;
          end else begin
            hold_cnt_nx = hold_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx != state) begin
      hold_cnt_nx = '0;
    end
    if (state_nx == G0) begin
      last_owner_nx = 1'b0;
    end else if (state_nx == G1) begin
      last_owner_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      hold_cnt   <= hold_cnt_nx;
    end
  end

  // Read data returns to the issuing master one cycle after the accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= acc0 && (m0_byteen == 4'b0000);
      m1_rvalid <= acc1 && (m1_byteen == 4'b0000);
      if (acc0 && (m0_byteen == 4'b0000)) begin
        m0_rdata <= s_rdata;
      end
      if (acc1 && (m1_byteen == 4'b0000)) begin
        m1_rdata <= s_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small bridge model
// (16-word memory plus a free-running timer at 0x7F04).
module tb_data_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_byteen;
  logic        m0_gnt;
  logic [31:0] m0_rdata;
  logic        m0_rvalid;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_byteen;
  logic        m1_gnt;
  logic [31:0] m1_rdata;
  logic        m1_rvalid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_byteen;
  logic [31:0] s_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [16];
  logic [31:0] timer_cnt;
  logic [31:0] exp_t;
  int          checks;
  int          errors;

  data_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_byteen (m0_byteen),
    .m0_gnt    (m0_gnt),
    .m0_rdata  (m0_rdata),
    .m0_rvalid (m0_rvalid),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_byteen (m1_byteen),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .m1_rvalid (m1_rvalid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_byteen  (s_byteen),
    .s_rdata   (s_rdata),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    timer_cnt = 32'h0001_0000;
    for (int i = 0; i < 16; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    timer_cnt <= timer_cnt + 32'd1;
    for (int b = 0; b < 4; b++) begin
      if (s_byteen[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
  end

  always_comb begin
    if (s_addr == 32'h0000_7F04) s_rdata = timer_cnt;
    else s_rdata = mem[s_addr[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_byteen = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_byteen = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  logic [1:0]  exp_own;
  logic [31:0] exp_addr;

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_ctl", {22'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                      owner, s_byteen}, 32'h0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1;

    for (int i = 0; i < 10; i++) begin
      step(); #2;
      check($sformatf("idle_ctl%0d", i),
            {22'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
             owner, s_byteen}, 32'h0);
      check($sformatf("idle_bus%0d", i), s_addr | s_wdata, 32'h0);
      check($sformatf("idle_rd%0d", i), m0_rdata | m1_rdata, 32'h0);
    end

    step();
    m0_req = 1; m0_addr = 32'h10;
    m0_wdata = 32'h1234_5678; m0_byteen = 4'hF;
    #2;
    check("wr_gnt_lat", m0_gnt, 0);
    check("wr_bus_off", s_byteen, 0);
    step(); #2;
    check("wr_gnt", m0_gnt, 1);
    check("wr_be", s_byteen, 4'hF);
    check("wr_addr", s_addr, 32'h10);
    check("wr_data", s_wdata, 32'h1234_5678);
    step();
    m0_byteen = 4'h0; m0_wdata = 0;
    #2;
    check("rd_be", s_byteen, 0);
    check("rd_addr", s_addr, 32'h10);
    check("rd_no_rv_wr", m0_rvalid, 0);
    step();
    m0_req = 0;
    #2;
    check("rd_rvalid", m0_rvalid, 1);
    check("rd_rdata", m0_rdata, 32'h1234_5678);
    check("rd_m1_rv", m1_rvalid, 0);
    step(); #2;
    check("rd_rv_end", m0_rvalid, 0);
    check("rd_hold", m0_rdata, 32'h1234_5678);
    check("rd_owner", owner, 2'b00);

    do_reset();
    step();
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h24;
    #2;
    check("ct_own0", owner, 2'b00);
    for (int i = 1; i <= 17; i++) begin
      step(); #2;
      exp_own  = (i <= 8) ? 2'b01 : (i <= 16) ? 2'b10 : 2'b01;
      exp_addr = (exp_own == 2'b01) ? 32'h20 : 32'h24;
      check($sformatf("ct_owner%0d", i), owner, exp_own);
      check($sformatf("ct_addr%0d", i), s_addr, exp_addr);
      check($sformatf("ct_rv0_%0d", i), m0_rvalid,
            (i >= 2 && i <= 9) ? 1 : 0);
      check($sformatf("ct_rv1_%0d", i), m1_rvalid,
            (i >= 10 && i <= 17) ? 1 : 0);
    end
    idle_inputs();

    do_reset();
    step();
    m0_req = 1; m0_addr = 32'h30;
    m1_req = 1; m1_addr = 32'h34;
    repeat (3) step();
    step();
    m1_req = 0;
    #2;
    check("ho_c4_own", owner, 2'b01);
    step();
    m0_req = 0; m1_req = 1;
    #2;
    check("ho_c5_gnt1", m1_gnt, 0);
    check("ho_c5_own", owner, 2'b01);
    step();
    m0_req = 1;
    #2;
    check("ho_gnt1", m1_gnt, 1);
    check("ho_own", owner, 2'b10);
    check("ho_addr", s_addr, 32'h34);
    for (int i = 7; i <= 14; i++) begin
      step(); #2;
      check($sformatf("ho_owner%0d", i), owner,
            (i <= 13) ? 2'b10 : 2'b01);
    end
    idle_inputs();

    do_reset();
    step();
    m1_req = 1; m1_addr = 32'h0000_7F04; m1_byteen = 0;
    #2;
    check("tm_gnt_lat", m1_gnt, 0);
    step(); #2;
    check("tm_addr", s_addr, 32'h0000_7F04);
    check("tm_be", s_byteen, 0);
    check("tm_gnt", m1_gnt, 1);
    exp_t = timer_cnt;
    step();
    m1_req = 0;
    #2;
    check("tm_rvalid", m1_rvalid, 1);
    check("tm_rdata", m1_rdata, exp_t);
    check("tm_m0_rv", m0_rvalid, 0);
    step(); #2;
    check("tm_rv_end", m1_rvalid, 0);
    check("tm_m0_rv2", m0_rvalid, 0);

    do_reset();
    step();
    m0_req = 1; m0_addr = 32'h10; m0_byteen = 0;
    step();
    step();
    reset_n = 0;
    m0_req = 0;
    #1;
    check("mr_rv_imm", m0_rvalid, 0);
    check("mr_rd_imm", m0_rdata, 0);
    check("mr_own_imm", owner, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      check($sformatf("mr_rv%0d", i), m0_rvalid, 0);
      check($sformatf("mr_own%0d", i), owner, 2'b00);
      check($sformatf("mr_rd%0d", i), m0_rdata, 0);
    end
    m0_req = 1; m0_addr = 32'h10;
    m1_req = 1; m1_addr = 32'h14;
    step(); #2;
    check("mr_last_own", owner, 2'b01);
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
